// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: MEM pipeline stage of a five-stage CPU.
//
// Issues a single data-memory request for loads/stores, stalls the upstream
// pipeline while the access is outstanding, resolves branches, and registers
// the MEM/WB pipeline outputs.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   MEM_PCaddr, MEM_zf         branch target and ALU zero flag from EX/MEM
//   MEM_ALUres, MEM_WrData     ALU result / memory byte address, store data
//   MEM_RegWr, MEM_WB, MEM_M   destination reg, WB controls, {Branch,MemRead,MemWrite}
//   dm_req/dm_we/dm_addr/dm_wdata   registered data-memory request
//   dm_rdata, dm_ack           read data and one-cycle completion pulse
//   stall                      freezes PC, IF/ID, ID/EX, EX/MEM
//   PCSrc, BrTarget            branch taken, branch target
//   WB_RdData, WB_ALUres, WB_RegWr, WB_WB   MEM/WB register outputs
//   err                        sticky: access timeout or misaligned access
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MEM_PCaddr,
    input  logic        MEM_zf,
    input  logic [31:0] MEM_ALUres,
    input  logic [31:0] MEM_WrData,
    input  logic [4:0]  MEM_RegWr,
    input  logic [1:0]  MEM_WB,
    input  logic [2:0]  MEM_M,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] BrTarget,
    output logic [31:0] WB_RdData,
    output logic [31:0] WB_ALUres,
    output logic [4:0]  WB_RegWr,
    output logic [1:0]  WB_WB,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before the wait is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] rd_hold_q, rd_hold_d;
    logic [31:0] wb_rd_data_q, wb_rd_data_d;
    logic [31:0] wb_alu_res_q, wb_alu_res_d;
    logic [4:0]  wb_reg_wr_q, wb_reg_wr_d;
    logic [1:0]  wb_wb_q, wb_wb_d;

    logic access;
    logic aligned;
    logic misaligned;
    logic stall_int;

    assign access     = MEM_M[1] | MEM_M[0];
    assign aligned    = (MEM_ALUres[1:0] == 2'b00);
    assign misaligned = (state_q == IDLE) && access && !aligned;
    // Stall already in the entry cycle so EX/MEM holds the instruction
    // until the result comes back; DONE releases the pipeline.
    assign stall_int  = ((state_q == IDLE) && access && aligned) || (state_q == BUSY);

    assign stall     = stall_int;
    assign PCSrc     = MEM_M[2] & MEM_zf & ~stall_int;
    assign BrTarget  = MEM_PCaddr;

    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign err       = err_q;
    assign WB_RdData = wb_rd_data_q;
    assign WB_ALUres = wb_alu_res_q;
    assign WB_RegWr  = wb_reg_wr_q;
    assign WB_WB     = wb_wb_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        dm_req_d     = dm_req_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        rd_hold_d    = rd_hold_q;
        wb_rd_data_d = wb_rd_data_q;
        wb_alu_res_d = wb_alu_res_q;
        wb_reg_wr_d  = wb_reg_wr_q;
        wb_wb_d      = wb_wb_q;

        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    state_d    = BUSY;
                    dm_req_d   = 1'b1;
                    // MemRead takes priority when both access bits are set.
                    dm_we_d    = ~MEM_M[1];
                    dm_addr_d  = {MEM_ALUres[31:2], 2'b00};
                    dm_wdata_d = MEM_WrData;
                    cnt_d      = 8'd0;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                // An ack on the final wait cycle still completes normally.
                if (dm_ack) begin
                    rd_hold_d = dm_rdata;
                    dm_req_d  = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    rd_hold_d = 32'd0;
                    dm_req_d  = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // Never re-issue: the instruction still sitting in EX/MEM is
                // the one just completed and advances on this edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stall_int) begin
            wb_wb_d = 2'b00;
        end else begin
            wb_alu_res_d = MEM_ALUres;
            wb_reg_wr_d  = MEM_RegWr;
            wb_wb_d      = misaligned ? 2'b00 : MEM_WB;
            // dm_we_q still describes the access that just finished.
            wb_rd_data_d = ((state_q == DONE) && !dm_we_q) ? rd_hold_q : MEM_ALUres;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= 32'd0;
            dm_wdata_q   <= 32'd0;
            rd_hold_q    <= 32'd0;
            wb_rd_data_q <= 32'd0;
            wb_alu_res_q <= 32'd0;
            wb_reg_wr_q  <= 5'd0;
            wb_wb_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            rd_hold_q    <= rd_hold_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_alu_res_q <= wb_alu_res_d;
            wb_reg_wr_q  <= wb_reg_wr_d;
            wb_wb_q      <= wb_wb_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: self-checking bench for mem_stage. Each instruction presented
// to the stage is described as a transaction; a transaction-level model
// predicts stall length, request contents and the resulting MEM/WB values.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MEM_PCaddr = '0;
    logic        MEM_zf = 1'b0;
    logic [31:0] MEM_ALUres = '0;
    logic [31:0] MEM_WrData = '0;
    logic [4:0]  MEM_RegWr = '0;
    logic [1:0]  MEM_WB = '0;
    logic [2:0]  MEM_M = '0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        stall, PCSrc;
    logic [31:0] BrTarget, WB_RdData, WB_ALUres;
    logic [4:0]  WB_RegWr;
    logic [1:0]  WB_WB;
    logic        err;

    int passed = 0;
    int total  = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_PCaddr(MEM_PCaddr), .MEM_zf(MEM_zf), .MEM_ALUres(MEM_ALUres),
        .MEM_WrData(MEM_WrData), .MEM_RegWr(MEM_RegWr), .MEM_WB(MEM_WB), .MEM_M(MEM_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .PCSrc(PCSrc),
        .BrTarget(BrTarget), .WB_RdData(WB_RdData), .WB_ALUres(WB_ALUres),
        .WB_RegWr(WB_RegWr), .WB_WB(WB_WB), .err(err)
    );

    typedef struct packed {
        logic [2:0]  m;
        logic        zf;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  wb;
        int          n_ack;   // BUSY cycle carrying dm_ack; outside 1..TMO = never
    } txn_t;

    typedef struct packed {
        int          stall_n;
        int          req_n;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  regwr;
        logic [1:0]  wb;
        logic        err;
        logic        pcsrc0;
    } exp_t;

    typedef struct packed {
        logic        done;
        int          stall_n;
        int          req_n;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stable;
        logic        bubble_ok;
        logic        pc_leak;
        logic        pcsrc0;
        logic [31:0] brt0;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  regwr;
        logic [1:0]  wb;
        logic        err;
        logic        reissue;
    } obs_t;

    // Transaction-level reference: what one instruction in MEM should produce.
    function automatic exp_t model(input txn_t t, input logic err_in);
        exp_t e;
        logic acc, al, tmo;
        int   w;
        acc = t.m[1] | t.m[0];
        al  = (t.alu[1:0] == 2'b00);
        tmo = (t.n_ack < 1) || (t.n_ack > TMO);
        w   = tmo ? TMO : t.n_ack;
        e.alu = t.alu; e.regwr = t.rd; e.we = ~t.m[1]; e.addr = t.alu; e.wdata = t.wdata;
        if (acc && al) begin
            e.stall_n = w + 1;
            e.req_n   = w;
            e.wb      = t.wb;
            e.rd      = t.m[1] ? (tmo ? 32'd0 : t.rdata) : t.alu;
            e.err     = err_in | tmo;
            e.pcsrc0  = 1'b0;
        end else begin
            e.stall_n = 0;
            e.req_n   = 0;
            e.wb      = acc ? 2'b00 : t.wb;
            e.rd      = t.alu;
            e.err     = err_in | acc;
            e.pcsrc0  = t.m[2] & t.zf;
        end
        return e;
    endfunction

    // Presents one instruction (called and returns at posedge+1), serves the
    // memory side, and collects what the stage did up to the releasing edge.
    task automatic run_txn(input txn_t t, output obs_t o);
        int k;
        o = '0;
        o.stable = 1'b1; o.bubble_ok = 1'b1;
        MEM_M = t.m; MEM_zf = t.zf; MEM_PCaddr = t.pc; MEM_ALUres = t.alu;
        MEM_WrData = t.wdata; MEM_RegWr = t.rd; MEM_WB = t.wb;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (dm_req) begin
                k++;
                o.req_n++;
                if (k == 1) begin
                    o.we = dm_we; o.addr = dm_addr; o.wdata = dm_wdata;
                end else if (dm_we !== o.we || dm_addr !== o.addr || dm_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                dm_ack   = (k == t.n_ack);
                dm_rdata = (k == t.n_ack) ? t.rdata : $urandom;
            end else begin
                // Stray acks outside an access must have no effect.
                dm_ack   = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
            end
            #1;
            if (c == 0) begin
                o.pcsrc0 = PCSrc; o.brt0 = BrTarget;
            end
            if (stall && PCSrc) o.pc_leak = 1'b1;
            if (!stall) begin
                o.done = 1'b1;
                @(posedge clk); #1;
                break;
            end
            o.stall_n++;
            @(posedge clk); #1;
            if (WB_WB !== 2'b00) o.bubble_ok = 1'b0;
        end
        dm_ack = 1'b0;
        o.rd = WB_RdData; o.alu = WB_ALUres; o.regwr = WB_RegWr; o.wb = WB_WB;
        o.err = err; o.reissue = dm_req;
        MEM_M = 3'b000;
    endtask

    task automatic do_reset;
        MEM_M = 3'b000; dm_ack = 1'b0;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        err_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dm_req !== 1'b0) $display("FAIL reset dm_req got %b want 0", dm_req); else passed++;
        total++; if (dm_we !== 1'b0) $display("FAIL reset dm_we got %b want 0", dm_we); else passed++;
        total++; if (dm_addr !== 32'd0) $display("FAIL reset dm_addr got %h want 0", dm_addr); else passed++;
        total++; if (dm_wdata !== 32'd0) $display("FAIL reset dm_wdata got %h want 0", dm_wdata); else passed++;
        total++; if (WB_RdData !== 32'd0) $display("FAIL reset WB_RdData got %h want 0", WB_RdData); else passed++;
        total++; if (WB_ALUres !== 32'd0) $display("FAIL reset WB_ALUres got %h want 0", WB_ALUres); else passed++;
        total++; if (WB_RegWr !== 5'd0) $display("FAIL reset WB_RegWr got %h want 0", WB_RegWr); else passed++;
        total++; if (WB_WB !== 2'b00) $display("FAIL reset WB_WB got %b want 00", WB_WB); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset err got %b want 0", err); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset stall got %b want 0", stall); else passed++;
        @(negedge clk); rst_n = 1'b1;
        err_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        txn_t t; obs_t o; exp_t e;
        t = '{m:3'b010, zf:1'b0, pc:32'h0, alu:32'h100, wdata:32'h0, rdata:32'hDEADBEEF,
              rd:5'd5, wb:2'b11, n_ack:3};
        e = model(t, err_m);
        run_txn(t, o);
        total++; if (o.done !== 1'b1) $display("FAIL load completion got %b want 1", o.done); else passed++;
        total++; if (o.stall_n !== 4) $display("FAIL load stall_cycles got %0d want 4", o.stall_n); else passed++;
        total++; if (o.addr !== 32'h100) $display("FAIL load dm_addr got %h want 100", o.addr); else passed++;
        total++; if (o.we !== 1'b0) $display("FAIL load dm_we got %b want 0", o.we); else passed++;
        total++; if (o.rd !== 32'hDEADBEEF) $display("FAIL load WB_RdData got %h want deadbeef", o.rd); else passed++;
        total++; if (o.wb !== 2'b11) $display("FAIL load WB_WB got %b want 11", o.wb); else passed++;
        total++; if (o.stable !== 1'b1) $display("FAIL load req_stable got %b want 1", o.stable); else passed++;
        total++; if (o.bubble_ok !== 1'b1) $display("FAIL load stall_bubble got %b want 1", o.bubble_ok); else passed++;
        total++; if (o.err !== e.err) $display("FAIL load err got %b want %b", o.err, e.err); else passed++;
        err_m = e.err;
    endtask

    task automatic test_store;
        txn_t t; obs_t o; exp_t e;
        t = '{m:3'b001, zf:1'b0, pc:32'h0, alu:32'h40, wdata:32'h12345678, rdata:32'hCAFEF00D,
              rd:5'd9, wb:2'b00, n_ack:1};
        e = model(t, err_m);
        run_txn(t, o);
        total++; if (o.we !== 1'b1) $display("FAIL store dm_we got %b want 1", o.we); else passed++;
        total++; if (o.wdata !== 32'h12345678) $display("FAIL store dm_wdata got %h want 12345678", o.wdata); else passed++;
        total++; if (o.addr !== 32'h40) $display("FAIL store dm_addr got %h want 40", o.addr); else passed++;
        total++; if (o.req_n !== 1) $display("FAIL store req_cycles got %0d want 1", o.req_n); else passed++;
        total++; if (o.stall_n !== e.stall_n) $display("FAIL store stall_cycles got %0d want %0d", o.stall_n, e.stall_n); else passed++;
        total++; if (o.reissue !== 1'b0) $display("FAIL store reissue got %b want 0", o.reissue); else passed++;
        total++; if (o.rd !== e.rd) $display("FAIL store WB_RdData got %h want %h", o.rd, e.rd); else passed++;
        err_m = e.err;
    endtask

    task automatic test_branch;
        txn_t t; obs_t o;
        t = '{m:3'b100, zf:1'b1, pc:32'h200, alu:32'h7, wdata:32'h0, rdata:32'h0,
              rd:5'd0, wb:2'b00, n_ack:0};
        run_txn(t, o);
        total++; if (o.pcsrc0 !== 1'b1) $display("FAIL branch_taken PCSrc got %b want 1", o.pcsrc0); else passed++;
        total++; if (o.brt0 !== 32'h200) $display("FAIL branch BrTarget got %h want 200", o.brt0); else passed++;
        total++; if (o.stall_n !== 0) $display("FAIL branch stall_cycles got %0d want 0", o.stall_n); else passed++;
        t.zf = 1'b0;
        run_txn(t, o);
        total++; if (o.pcsrc0 !== 1'b0) $display("FAIL branch_not_taken PCSrc got %b want 0", o.pcsrc0); else passed++;
    endtask

    task automatic test_timeout;
        txn_t t; obs_t o; exp_t e;
        t = '{m:3'b010, zf:1'b0, pc:32'h0, alu:32'h300, wdata:32'h0, rdata:32'h55AA55AA,
              rd:5'd3, wb:2'b11, n_ack:0};
        e = model(t, err_m);
        run_txn(t, o);
        total++; if (o.done !== 1'b1) $display("FAIL timeout completion got %b want 1", o.done); else passed++;
        total++; if (o.req_n !== TMO) $display("FAIL timeout busy_cycles got %0d want %0d", o.req_n, TMO); else passed++;
        total++; if (o.err !== 1'b1) $display("FAIL timeout err got %b want 1", o.err); else passed++;
        total++; if (o.rd !== 32'd0) $display("FAIL timeout WB_RdData got %h want 0", o.rd); else passed++;
        total++; if (o.stall_n !== e.stall_n) $display("FAIL timeout stall_cycles got %0d want %0d", o.stall_n, e.stall_n); else passed++;
        err_m = e.err;
        // Pipeline must resume afterwards; err stays sticky.
        t = '{m:3'b000, zf:1'b0, pc:32'h0, alu:32'h1234, wdata:32'h0, rdata:32'h0,
              rd:5'd4, wb:2'b10, n_ack:0};
        run_txn(t, o);
        total++; if (o.stall_n !== 0) $display("FAIL timeout_resume stall_cycles got %0d want 0", o.stall_n); else passed++;
        total++; if (o.wb !== 2'b10) $display("FAIL timeout_resume WB_WB got %b want 10", o.wb); else passed++;
        total++; if (o.err !== 1'b1) $display("FAIL timeout_sticky err got %b want 1", o.err); else passed++;
        do_reset;
    endtask

    task automatic test_ack_boundary;
        txn_t t; obs_t o;
        t = '{m:3'b011, zf:1'b0, pc:32'h0, alu:32'h88, wdata:32'h1, rdata:32'h0BADCAFE,
              rd:5'd6, wb:2'b11, n_ack:TMO};
        run_txn(t, o);
        total++; if (o.err !== 1'b0) $display("FAIL ack_last_cycle err got %b want 0", o.err); else passed++;
        total++; if (o.rd !== 32'h0BADCAFE) $display("FAIL ack_last_cycle WB_RdData got %h want 0badcafe", o.rd); else passed++;
        total++; if (o.we !== 1'b0) $display("FAIL read_priority dm_we got %b want 0", o.we); else passed++;
    endtask

    task automatic test_misaligned;
        txn_t t; obs_t o;
        t = '{m:3'b010, zf:1'b0, pc:32'h0, alu:32'h102, wdata:32'h0, rdata:32'h0,
              rd:5'd8, wb:2'b11, n_ack:1};
        run_txn(t, o);
        total++; if (o.req_n !== 0) $display("FAIL misaligned req_cycles got %0d want 0", o.req_n); else passed++;
        total++; if (o.stall_n !== 0) $display("FAIL misaligned stall_cycles got %0d want 0", o.stall_n); else passed++;
        total++; if (o.err !== 1'b1) $display("FAIL misaligned err got %b want 1", o.err); else passed++;
        total++; if (o.wb !== 2'b00) $display("FAIL misaligned WB_WB got %b want 00", o.wb); else passed++;
        do_reset;
    endtask

    task automatic test_reset_mid_busy;
        MEM_M = 3'b010; MEM_ALUres = 32'h80; MEM_WB = 2'b11; MEM_RegWr = 5'd7; dm_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (dm_req !== 1'b1) $display("FAIL rst_busy pre_req got %b want 1", dm_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (dm_req !== 1'b0) $display("FAIL rst_busy dm_req got %b want 0", dm_req); else passed++;
        total++; if (WB_WB !== 2'b00) $display("FAIL rst_busy WB_WB got %b want 00", WB_WB); else passed++;
        total++; if (WB_RdData !== 32'd0) $display("FAIL rst_busy WB_RdData got %h want 0", WB_RdData); else passed++;
        total++; if (WB_ALUres !== 32'd0) $display("FAIL rst_busy WB_ALUres got %h want 0", WB_ALUres); else passed++;
        total++; if (WB_RegWr !== 5'd0) $display("FAIL rst_busy WB_RegWr got %h want 0", WB_RegWr); else passed++;
        MEM_M = 3'b000;
        @(negedge clk); rst_n = 1'b1;
        err_m = 1'b0;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0; MEM_ALUres = 32'h44; MEM_WB = 2'b10;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL rst_late_ack stall got %b want 0", stall); else passed++;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        total++; if (dm_req !== 1'b0) $display("FAIL rst_late_ack dm_req got %b want 0", dm_req); else passed++;
        total++; if (WB_RdData !== 32'h44) $display("FAIL rst_late_ack WB_RdData got %h want 44", WB_RdData); else passed++;
        total++; if (WB_WB !== 2'b10) $display("FAIL rst_late_ack WB_WB got %b want 10", WB_WB); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rst_late_ack err got %b want 0", err); else passed++;
    endtask

    task automatic test_random;
        txn_t t; obs_t o; exp_t e;
        logic acc_al;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: t.m = 3'b000; 1: t.m = 3'b010; 2: t.m = 3'b001; 3: t.m = 3'b011;
                4: t.m = 3'b100; 5: t.m = 3'b110; default: t.m = 3'b101;
            endcase
            t.zf = 1'($urandom_range(0, 1));
            t.pc = $urandom; t.alu = $urandom; t.wdata = $urandom; t.rdata = $urandom;
            if ($urandom_range(0, 3) != 0) t.alu[1:0] = 2'b00;
            t.rd = 5'($urandom); t.wb = 2'($urandom);
            t.n_ack = int'($urandom_range(0, TMO + 1));
            e = model(t, err_m);
            acc_al = (e.stall_n != 0);
            run_txn(t, o);
            total++; if (o.done !== 1'b1) $display("FAIL rnd%0d completion got %b want 1", i, o.done); else passed++;
            total++; if (o.stall_n !== e.stall_n) $display("FAIL rnd%0d stall_cycles got %0d want %0d", i, o.stall_n, e.stall_n); else passed++;
            total++; if (o.req_n !== e.req_n) $display("FAIL rnd%0d req_cycles got %0d want %0d", i, o.req_n, e.req_n); else passed++;
            total++; if (o.pcsrc0 !== e.pcsrc0) $display("FAIL rnd%0d PCSrc got %b want %b", i, o.pcsrc0, e.pcsrc0); else passed++;
            total++; if (o.brt0 !== t.pc) $display("FAIL rnd%0d BrTarget got %h want %h", i, o.brt0, t.pc); else passed++;
            total++; if (o.pc_leak !== 1'b0) $display("FAIL rnd%0d PCSrc_during_stall got %b want 0", i, o.pc_leak); else passed++;
            total++; if (o.rd !== e.rd) $display("FAIL rnd%0d WB_RdData got %h want %h", i, o.rd, e.rd); else passed++;
            total++; if (o.alu !== e.alu) $display("FAIL rnd%0d WB_ALUres got %h want %h", i, o.alu, e.alu); else passed++;
            total++; if (o.regwr !== e.regwr) $display("FAIL rnd%0d WB_RegWr got %h want %h", i, o.regwr, e.regwr); else passed++;
            total++; if (o.wb !== e.wb) $display("FAIL rnd%0d WB_WB got %b want %b", i, o.wb, e.wb); else passed++;
            total++; if (o.err !== e.err) $display("FAIL rnd%0d err got %b want %b", i, o.err, e.err); else passed++;
            total++; if (o.reissue !== 1'b0) $display("FAIL rnd%0d reissue got %b want 0", i, o.reissue); else passed++;
            if (acc_al) begin
                total++; if (o.we !== e.we) $display("FAIL rnd%0d dm_we got %b want %b", i, o.we, e.we); else passed++;
                total++; if (o.addr !== e.addr) $display("FAIL rnd%0d dm_addr got %h want %h", i, o.addr, e.addr); else passed++;
                if (!t.m[1]) begin
                    total++; if (o.wdata !== e.wdata) $display("FAIL rnd%0d dm_wdata got %h want %h", i, o.wdata, e.wdata); else passed++;
                end
                total++; if (o.stable !== 1'b1) $display("FAIL rnd%0d req_stable got %b want 1", i, o.stable); else passed++;
                total++; if (o.bubble_ok !== 1'b1) $display("FAIL rnd%0d stall_bubble got %b want 1", i, o.bubble_ok); else passed++;
            end
            err_m = e.err;
            if (i % 20 == 19) do_reset;
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_branch;
        test_timeout;
        test_ack_boundary;
        test_misaligned;
        test_reset_mid_busy;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max dm_ack wait cycles before abort (1..255).
REQ-002 SHALL have port clk  in  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port MEM_PCaddr  in  32  branch target from EX/MEM register.
REQ-005 SHALL have port MEM_zf  in  1  ALU zero flag.
REQ-006 SHALL have port MEM_ALUres  in  32  ALU result; data-memory byte address when accessing.
REQ-007 SHALL have port MEM_WrData  in  32  store data.
REQ-008 SHALL have port MEM_RegWr  in  5  destination register number.
REQ-009 SHALL have port MEM_WB  in  2  [1]=RegWrite, [0]=MemtoReg.
REQ-010 SHALL have port MEM_M  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
REQ-011 SHALL have port dm_req  out  1  data-memory request, registered.
REQ-012 SHALL have port dm_we  out  1  1=write, 0=read, registered.
REQ-013 SHALL have port dm_addr  out  32  word-aligned address, registered.
REQ-014 SHALL have port dm_wdata  out  32  write data, registered.
REQ-015 SHALL have port dm_rdata  in  32  read data, valid with dm_ack.
REQ-016 SHALL have port dm_ack  in  1  one-cycle completion pulse.
REQ-017 SHALL have port stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-018 SHALL have port PCSrc  out  1  branch taken.
REQ-019 SHALL have port BrTarget  out  32  branch target address.
REQ-020 SHALL have port WB_RdData  out  32  loaded word to writeback.
REQ-021 SHALL have port WB_ALUres  out  32  ALU result to writeback.
REQ-022 SHALL have port WB_RegWr  out  5  destination register to writeback.
REQ-023 SHALL have port WB_WB  out  2  writeback controls.
REQ-024 SHALL have port err  out  1  sticky error: timeout or misaligned access.

Function
REQ-025 SHALL implement FSM IDLE, BUSY, DONE; access = MEM_M[1] | MEM_M[0]; MemRead wins if both are set (dm_we=0).
REQ-026 In IDLE with access and MEM_ALUres[1:0]==0: next edge SHALL set dm_req=1, latch dm_we, dm_addr, dm_wdata, clear wait counter, go BUSY.
REQ-027 In BUSY: dm_req, dm_we, dm_addr, dm_wdata SHALL stay stable; counter increments each cycle without dm_ack.
REQ-028 In BUSY with dm_ack: SHALL capture dm_rdata into a read holding register, drop dm_req next edge, go DONE.
REQ-029 In BUSY with counter==TIMEOUT-1 and no dm_ack: SHALL set err, load 0 into the read holding register, drop dm_req, go DONE. dm_ack in that same cycle wins (normal completion, no err).
REQ-030 DONE SHALL always go to IDLE next edge without issuing a new request, even if access is still set.
REQ-031 dm_ack outside BUSY SHALL be ignored.
REQ-032 stall SHALL be combinational: 1 when (IDLE & access & aligned) or BUSY, else 0; stall=0 in DONE.
REQ-033 Misaligned access (IDLE, access, MEM_ALUres[1:0]!=0) SHALL issue no request, not stall, set err, and send WB_WB=00 at next edge.
REQ-034 PCSrc SHALL = MEM_M[2] & MEM_zf & ~stall, combinational; BrTarget SHALL = MEM_PCaddr.
REQ-035 On each edge with stall=0: WB_ALUres<=MEM_ALUres, WB_RegWr<=MEM_RegWr, WB_WB<=MEM_WB (00 if misaligned).
REQ-036 On the same stall=0 edges, WB_RdData SHALL load the read holding register when leaving DONE after a read, else MEM_ALUres.
REQ-037 On each edge with stall=1: WB_WB SHALL be 00 (bubble); WB_RdData, WB_ALUres, WB_RegWr hold.
REQ-038 Load latency: request issued 1 edge after entry; result reaches WB 1 edge after DONE; stall length = ack wait + 1 cycles.

Reset
REQ-039 rst_n=0 SHALL asynchronously force IDLE, counter=0, err=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, all WB_* outputs=0, and the read holding register=0.
REQ-040 Reset during BUSY SHALL abandon the access; a late dm_ack after release SHALL be ignored.

Verification
REQ-041 Load with MEM_M=010, ALUres=0x100, dm_ack 3 cycles after req, rdata=0xDEADBEEF -> stall high 4 cycles, dm_addr=0x100, WB_RdData=0xDEADBEEF, WB_WB=MEM_WB.
REQ-042 Store with MEM_M=001, ALUres=0x40, WrData=0x12345678, ack 1 cycle after req -> dm_we=1, dm_wdata=0x12345678, single request, no re-issue in DONE.
REQ-043 TIMEOUT=4, load, no dm_ack -> err=1 after 4 BUSY cycles, WB_RdData=0, pipeline resumes.
REQ-044 Branch with MEM_M=100, zf=1, PCaddr=0x200 -> PCSrc=1, BrTarget=0x200, no stall; zf=0 -> PCSrc=0.
REQ-045 Load to ALUres=0x102 -> no dm_req, stall=0, err=1, WB_WB=00.
REQ-046 rst_n low mid-BUSY, then dm_ack after release -> dm_req=0, FSM IDLE, WB outputs 0, ack ignored.
